// File: rtl/arp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arp_pkg
// Purpose  : Shared constants and types for the ARP transmit path.
//            Ethernet/ARP field values, per-section byte counts and the
//            one-hot state type used by arp_tx.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  // Section lengths in bytes.
  localparam int PREAMBLE_LEN = 8;
  localparam int ETH_HDR_LEN  = 14;
  localparam int ARP_LEN      = 28;
  localparam int PAD_LEN      = 18;
  localparam int FCS_LEN      = 4;

  typedef enum logic [6:0] {
    ST_IDLE     = 7'b000_0001,
    ST_PREAMBLE = 7'b000_0010,
    ST_ETH_HEAD = 7'b000_0100,
    ST_ARP_DATA = 7'b000_1000,
    ST_PAD      = 7'b001_0000,
    ST_FCS      = 7'b010_0000,
    ST_IFG      = 7'b100_0000
  } arp_state_t;

endpackage : arp_pkg
`default_nettype wire

// File: rtl/arp_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : arp_tx_if
// Purpose  : Request handshake and GMII transmit bus of the ARP transmitter.
// Signals  : arp_tx_en/arp_tx_type/des_mac/des_ip - start request from the
//            control layer; busy/tx_done - status back to it;
//            gmii_tx_en/gmii_txd - GMII transmit byte stream.
// Modports : master - control layer / bench side
//            slave  - arp_tx side
// Revision : 1.0 - initial release
// ============================================================================
interface arp_tx_if;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_done;
  logic        busy;

  modport master (
    output arp_tx_en, arp_tx_type, des_mac, des_ip,
    input  gmii_tx_en, gmii_txd, tx_done, busy
  );

  modport slave (
    input  arp_tx_en, arp_tx_type, des_mac, des_ip,
    output gmii_tx_en, gmii_txd, tx_done, busy
  );
endinterface : arp_tx_if
`default_nettype wire

// File: rtl/arp_tx_crc32_d8.sv
`default_nettype none
// ============================================================================
// Module   : crc32_d8
// Purpose  : IEEE 802.3 CRC-32 (reflected poly 0xEDB88320), one byte per
//            clock. crc is the raw register (no final complement); the
//            caller inverts it when emitting the FCS.
// Ports    : clk, rst   - clock, asynchronous active-high reset
//            init       - load all-ones (priority over en)
//            en         - fold data into the register this cycle
//            data[7:0]  - byte to fold in
//            crc[31:0]  - current register value
//            crc_next   - register value after folding in data
// Revision : 1.0 - initial release
// ============================================================================
module crc32_d8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc,
  output logic [31:0] crc_next
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    logic [31:0] c;
    c = crc_q ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    crc_next = c;
  end

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (en) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule : crc32_d8
`default_nettype wire

// File: rtl/arp_tx.sv
`default_nettype none
// ============================================================================
// Module   : arp_tx
// Purpose  : Builds and sends one ARP request/reply frame on GMII TX:
//            preamble+SFD, Ethernet header, 28-byte ARP body, 18 pad bytes,
//            FCS, then an enforced inter-frame gap.
// Ports    : clk, rst            - GMII TX clock, async active-high reset
//            board_mac, board_ip - local addresses (sender fields)
//            tx_if (slave)       - start request, status, GMII TX bus
// Params   : IFG_CYCLES          - idle cycles after FCS (12..64)
// Revision : 1.0 - initial release
// ============================================================================
module arp_tx
  import arp_pkg::*;
#(
  parameter int IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] board_mac,
  input  logic [31:0] board_ip,
  arp_tx_if.slave     tx_if
);

  arp_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        type_q, type_d;
  logic [47:0] des_mac_q, des_mac_d;
  logic [31:0] des_ip_q, des_ip_d;
  logic [47:0] board_mac_q, board_mac_d;
  logic [31:0] board_ip_q, board_ip_d;
  logic        gmii_tx_en_q, gmii_tx_en_d;
  logic [7:0]  gmii_txd_q, gmii_txd_d;
  logic        tx_done_q, tx_done_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc_val;
  logic [31:0] crc_nxt;

  logic [ETH_HDR_LEN*8-1:0] eth_hdr;
  logic [ARP_LEN*8-1:0]     arp_body;

  // Frame fields built from the latched copies only, so input changes while
  // busy cannot disturb the frame in flight.
  assign eth_hdr  = {(type_q ? des_mac_q : BCAST_MAC), board_mac_q, ETH_TYPE_ARP};
  assign arp_body = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN,
                     (type_q ? ARP_OP_REPLY : ARP_OP_REQ),
                     board_mac_q, board_ip_q,
                     (type_q ? des_mac_q : 48'h0), des_ip_q};

  crc32_d8 u_crc (
    .clk      (clk),
    .rst      (rst),
    .init     (crc_init),
    .en       (crc_en),
    .data     (gmii_txd_d),
    .crc      (crc_val),
    .crc_next (crc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 6'd1;
    type_d      = type_q;
    des_mac_d   = des_mac_q;
    des_ip_d    = des_ip_q;
    board_mac_d = board_mac_q;
    board_ip_d  = board_ip_q;
    tx_done_d   = 1'b0;
    accept      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (tx_if.arp_tx_en) begin
          accept      = 1'b1;
          state_d     = ST_PREAMBLE;
          type_d      = tx_if.arp_tx_type;
          des_mac_d   = tx_if.des_mac;
          des_ip_d    = tx_if.des_ip;
          board_mac_d = board_mac;
          board_ip_d  = board_ip;
        end
      end
      ST_PREAMBLE: if (cnt_q == 6'(PREAMBLE_LEN - 1)) state_d = ST_ETH_HEAD;
      ST_ETH_HEAD: if (cnt_q == 6'(ETH_HDR_LEN - 1))  state_d = ST_ARP_DATA;
      ST_ARP_DATA: if (cnt_q == 6'(ARP_LEN - 1))      state_d = ST_PAD;
      ST_PAD:      if (cnt_q == 6'(PAD_LEN - 1))      state_d = ST_FCS;
      ST_FCS: begin
        if (cnt_q == 6'(FCS_LEN - 1)) begin
          state_d   = ST_IFG;
          tx_done_d = 1'b1;
        end
      end
      ST_IFG:      if (cnt_q == 6'(IFG_CYCLES - 1))   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end

    // busy is derived from the current state, so it stays high through the
    // first IDLE cycle after the gap; that cycle can already accept a start.
    busy_d = accept || (state_q != ST_IDLE);

    // Output registers carry the byte for the position entered at the next
    // edge; the CRC folds in the same byte on the same edge, so the register
    // already covers the last pad byte when the first FCS byte is selected.
    gmii_tx_en_d = 1'b0;
    gmii_txd_d   = 8'h00;
    crc_init     = 1'b0;
    crc_en       = 1'b0;
    case (state_d)
      ST_PREAMBLE: begin
        gmii_tx_en_d = 1'b1;
        gmii_txd_d   = (cnt_d == 6'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
        crc_init     = 1'b1;
      end
      ST_ETH_HEAD: begin
        gmii_tx_en_d = 1'b1;
        gmii_txd_d   = eth_hdr[8*(ETH_HDR_LEN-1-int'(cnt_d)) +: 8];
        crc_en       = 1'b1;
      end
      ST_ARP_DATA: begin
        gmii_tx_en_d = 1'b1;
        gmii_txd_d   = arp_body[8*(ARP_LEN-1-int'(cnt_d)) +: 8];
        crc_en       = 1'b1;
      end
      ST_PAD: begin
        gmii_tx_en_d = 1'b1;
        gmii_txd_d   = 8'h00;
        crc_en       = 1'b1;
      end
      ST_FCS: begin
        // Complemented CRC, least-significant byte first.
        gmii_tx_en_d = 1'b1;
        gmii_txd_d   = ~crc_val[8*int'(cnt_d[1:0]) +: 8];
      end
      default: begin
        gmii_tx_en_d = 1'b0;
        gmii_txd_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      type_q       <= 1'b0;
      des_mac_q    <= '0;
      des_ip_q     <= '0;
      board_mac_q  <= '0;
      board_ip_q   <= '0;
      gmii_tx_en_q <= 1'b0;
      gmii_txd_q   <= 8'h00;
      tx_done_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      des_mac_q    <= des_mac_d;
      des_ip_q     <= des_ip_d;
      board_mac_q  <= board_mac_d;
      board_ip_q   <= board_ip_d;
      gmii_tx_en_q <= gmii_tx_en_d;
      gmii_txd_q   <= gmii_txd_d;
      tx_done_q    <= tx_done_d;
      busy_q       <= busy_d;
    end
  end

  assign tx_if.gmii_tx_en = gmii_tx_en_q;
  assign tx_if.gmii_txd   = gmii_txd_q;
  assign tx_if.tx_done    = tx_done_q;
  assign tx_if.busy       = busy_q;

endmodule : arp_tx
`default_nettype wire

// File: tb/tb_arp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_tx
// Purpose  : Self-checking bench for arp_tx. Expected frames are assembled
//            byte by byte from the ARP/Ethernet field layout, with a
//            bit-serial CRC-32, and compared with the captured GMII stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_tx;

  localparam int IFG = 12;
  localparam int FRAME_BYTES = 72;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] board_mac;
  logic [31:0] board_ip;

  arp_tx_if ifc ();

  arp_tx #(.IFG_CYCLES(IFG)) dut (
    .clk       (clk),
    .rst       (rst),
    .board_mac (board_mac),
    .board_ip  (board_ip),
    .tx_if     (ifc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  // Monitor: only this block writes the capture state.
  bq_t  cap_q;
  int   rise_q[$];
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   cyc = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ifc.gmii_tx_en === 1'b1) cap_q.push_back(ifc.gmii_txd);
    if (ifc.gmii_tx_en === 1'b1 && prev_en !== 1'b1) rise_q.push_back(cyc);
    prev_en = ifc.gmii_tx_en;
    if (ifc.tx_done === 1'b1) done_cnt = done_cnt + 1;
    if (ifc.busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1);
  end

  bq_t exp_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] crc32(input bq_t d, input int from);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = from; i < d.size(); i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic push_be(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic build_exp(input logic typ, input logic [47:0] bmac, input logic [31:0] bip,
                           input logic [47:0] dmac, input logic [31:0] dip);
    logic [31:0] fcs;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_be(typ ? {16'h0, dmac} : 64'hFFFF_FFFF_FFFF, 6);
    push_be({16'h0, bmac}, 6);
    push_be(64'h0806, 2);
    push_be(64'h0001, 2);
    push_be(64'h0800, 2);
    push_be(64'h06, 1);
    push_be(64'h04, 1);
    push_be(typ ? 64'h2 : 64'h1, 2);
    push_be({16'h0, bmac}, 6);
    push_be({32'h0, bip}, 4);
    push_be(typ ? {16'h0, dmac} : 64'h0, 6);
    push_be({32'h0, dip}, 4);
    repeat (18) exp_q.push_back(8'h00);
    fcs = crc32(exp_q, 8);
    for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
  endtask

  task automatic check_frame(input string tag, input int base);
    bq_t f;
    int  bad;
    int  n;
    f = cap_q[base:$];
    chk({tag, "_len"}, 64'(f.size()), 64'(FRAME_BYTES));
    bad = 0;
    n = (f.size() < exp_q.size()) ? f.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (f[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes_bad"}, 64'(bad), 64'd0);
    chk({tag, "_residue"}, 64'(crc32(f, 8)), 64'h2144_DF1C);
  endtask

  task automatic start(input logic typ, input logic [47:0] dmac, input logic [31:0] dip);
    @(negedge clk);
    ifc.arp_tx_en   = 1'b1;
    ifc.arp_tx_type = typ;
    ifc.des_mac     = dmac;
    ifc.des_ip      = dip;
    @(negedge clk);
    ifc.arp_tx_en   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int          base, d0, b0, r0;
    logic        typ;
    logic [47:0] dmac, bmac_s;
    logic [31:0] dip, bip_s;
    bit          ok;

    ifc.arp_tx_en   = 1'b0;
    ifc.arp_tx_type = 1'b0;
    ifc.des_mac     = '0;
    ifc.des_ip      = '0;
    board_mac       = 48'h0011_2233_4455;
    board_ip        = 32'hC0A8_0002;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 64'(ifc.gmii_tx_en), 64'd0);
    chk("rst_txd",   64'(ifc.gmii_txd),   64'd0);
    chk("rst_done",  64'(ifc.tx_done),    64'd0);
    chk("rst_busy",  64'(ifc.busy),       64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(ifc.busy), 64'd0);

    // Reply from the example addresses
    base = cap_q.size(); d0 = done_cnt; b0 = busy_cnt;
    start(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0003);
    chk("lat_tx_en", 64'(ifc.gmii_tx_en), 64'd1);
    chk("lat_busy",  64'(ifc.busy),       64'd1);
    chk("lat_txd",   64'(ifc.gmii_txd),   64'h55);
    wait_idle("reply");
    repeat (3) @(negedge clk);
    build_exp(1'b1, board_mac, board_ip, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0003);
    check_frame("reply", base);
    chk("reply_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("reply_busy_cyc", 64'(busy_cnt - b0), 64'(FRAME_BYTES + IFG + 1));

    // Request: destination MAC must be ignored
    base = cap_q.size();
    dmac = {16'($urandom), 32'($urandom)};
    start(1'b0, dmac, 32'h0A00_0001);
    wait_idle("req");
    build_exp(1'b0, board_mac, board_ip, dmac, 32'h0A00_0001);
    check_frame("req", base);

    // Randomized frames
    for (int k = 0; k < 4; k++) begin
      typ       = 1'($urandom_range(0, 1));
      dmac      = {16'($urandom), 32'($urandom)};
      dip       = 32'($urandom);
      board_mac = {16'($urandom), 32'($urandom)};
      board_ip  = 32'($urandom);
      base = cap_q.size();
      start(typ, dmac, dip);
      wait_idle("rand");
      build_exp(typ, board_mac, board_ip, dmac, dip);
      check_frame("rand", base);
    end

    // Busy rejection: extra pulses during the frame and during the gap
    base = cap_q.size(); d0 = done_cnt; b0 = busy_cnt;
    dmac = {16'($urandom), 32'($urandom)};
    dip  = 32'($urandom);
    start(1'b1, dmac, dip);
    repeat (3) @(negedge clk);
    ifc.arp_tx_en = 1'b1; ifc.arp_tx_type = 1'b0;
    @(negedge clk);
    ifc.arp_tx_en = 1'b0; ifc.arp_tx_type = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ifc.tx_done === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rej_done_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    ifc.arp_tx_en = 1'b1;
    @(negedge clk);
    ifc.arp_tx_en = 1'b0;
    wait_idle("rej");
    repeat (20) @(negedge clk);
    build_exp(1'b1, board_mac, board_ip, dmac, dip);
    check_frame("rej", base);
    chk("rej_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("rej_busy_cyc", 64'(busy_cnt - b0), 64'(FRAME_BYTES + IFG + 1));

    // Back-to-back with the start held high
    r0 = rise_q.size();
    @(negedge clk);
    ifc.arp_tx_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rise_q.size() >= r0 + 3) begin ok = 1'b1; break; end
    end
    ifc.arp_tx_en = 1'b0;
    if (!ok) chk("b2b_timeout", 64'd0, 64'd1);
    wait_idle("b2b");
    chk("b2b_gap1", 64'(rise_q[r0+1] - rise_q[r0]),   64'(FRAME_BYTES + IFG + 1));
    chk("b2b_gap2", 64'(rise_q[r0+2] - rise_q[r0+1]), 64'(FRAME_BYTES + IFG + 1));

    // Reset in the middle of ARP_DATA byte 10
    d0 = done_cnt;
    start(1'b1, 48'h0102_0304_0506, 32'h0A0B_0C0D);
    repeat (8 + 14 + 10) @(negedge clk);
    chk("mid_tx_en", 64'(ifc.gmii_tx_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx_en", 64'(ifc.gmii_tx_en), 64'd0);
    chk("mid_rst_busy",  64'(ifc.busy),       64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
    base = cap_q.size();
    dmac = {16'($urandom), 32'($urandom)};
    dip  = 32'($urandom);
    start(1'b1, dmac, dip);
    wait_idle("post_rst");
    build_exp(1'b1, board_mac, board_ip, dmac, dip);
    check_frame("post_rst", base);

    // Input stability after acceptance
    base   = cap_q.size();
    dmac   = {16'($urandom), 32'($urandom)};
    dip    = 32'($urandom);
    bmac_s = board_mac;
    bip_s  = board_ip;
    start(1'b1, dmac, dip);
    ifc.des_mac = ~dmac;
    board_ip    = ~bip_s;
    wait_idle("stable");
    build_exp(1'b1, bmac_s, bip_s, dmac, dip);
    check_frame("stable", base);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_arp_tx
`default_nettype wire
